// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: start bit, DATA_LEN data bits (LSB first), no parity, stop bit(s).
// Each completed frame produces a one-cycle o_rxDone strobe qualifying o_rxData and o_frameErr.
module uart_rx #(
  parameter int DATA_LEN = 8,
  parameter int SB_TICK  = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_tick,
  input  logic                i_uartRx,
  output logic [DATA_LEN-1:0] o_rxData,
  output logic                o_rxDone,
  output logic                o_frameErr,
  output logic [1:0]          o_dbgState
);

  // The tick counter must reach both 15 (data bits) and SB_TICK-1 (stop).
  localparam int TICK_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int TW       = $clog2(TICK_MAX);
  localparam int BW       = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

  localparam logic [TW-1:0] START_MID = TW'(7);
  localparam logic [TW-1:0] DATA_END  = TW'(15);
  localparam logic [TW-1:0] STOP_END  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              r_state;
  logic [TW-1:0]       r_tick_cnt;
  logic [BW-1:0]       r_bit_cnt;
  logic [DATA_LEN-1:0] r_shift;
  logic [DATA_LEN-1:0] w_shift_next;
  logic                r_sync1;
  logic                r_sync2;

  assign o_dbgState = r_state;

  // Two-flop synchronizer; reset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_uartRx;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_shift_next               = r_shift >> 1;
    w_shift_next[DATA_LEN-1]   = r_sync2;
  end

  // o_rxDone is a single-cycle strobe with no back-pressure: o_rxData and o_frameErr
  // are valid on the cycle it is high and hold until the next strobe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      o_rxData   <= '0;
      o_rxDone   <= 1'b0;
      o_frameErr <= 1'b0;
    end else begin
      o_rxDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_sync2) begin
            r_state    <= START;
            r_tick_cnt <= '0;
          end
        end
        START: begin
          if (i_tick) begin
            if (r_tick_cnt == START_MID) begin
              if (!r_sync2) begin
                r_state    <= DATA;
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (i_tick) begin
            if (r_tick_cnt == DATA_END) begin
              r_shift    <= w_shift_next;
              r_tick_cnt <= '0;
              if (r_bit_cnt == LAST_BIT) begin
                r_state <= STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (i_tick) begin
            if (r_tick_cnt == STOP_END) begin
              r_state    <= IDLE;
              o_rxDone   <= 1'b1;
              o_rxData   <= r_shift;
              o_frameErr <= ~r_sync2;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8-bit/1-stop instance and a 7-bit/2-stop instance
// share clock, reset and a tick that pulses every fourth clock.
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   = 1'b1;
  logic       tick  = 1'b0;
  logic       rx_a  = 1'b1;
  logic       rx_b  = 1'b1;
  logic [7:0] data_a;
  logic       done_a, err_a;
  logic [1:0] st_a;
  logic [6:0] data_b;
  logic       done_b, err_b;
  logic [1:0] st_b;

  uart_rx #(.DATA_LEN(8), .SB_TICK(16)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_uartRx(rx_a),
    .o_rxData(data_a), .o_rxDone(done_a), .o_frameErr(err_a), .o_dbgState(st_a)
  );

  uart_rx #(.DATA_LEN(7), .SB_TICK(32)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_uartRx(rx_b),
    .o_rxData(data_b), .o_rxDone(done_b), .o_frameErr(err_b), .o_dbgState(st_b)
  );

  int vectors     = 0;
  int miscompares = 0;
  int tick_count  = 0;
  int phase       = 0;

  // Scoreboard capture of every strobe: word, error flag and tick timestamp.
  logic [7:0] da_q[$];
  logic       ea_q[$];
  int         ta_q[$];
  logic [6:0] db_q[$];
  logic       eb_q[$];
  int         tb_q[$];
  int         dbl_a  = 0;
  int         dbl_b  = 0;
  logic       prev_a = 1'b0;
  logic       prev_b = 1'b0;

  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      da_q.push_back(data_a); ea_q.push_back(err_a); ta_q.push_back(tick_count);
    end
    if (done_b === 1'b1) begin
      db_q.push_back(data_b); eb_q.push_back(err_b); tb_q.push_back(tick_count);
    end
    if (done_a === 1'b1 && prev_a) dbl_a++;
    if (done_b === 1'b1 && prev_b) dbl_b++;
    prev_a = (done_a === 1'b1);
    prev_b = (done_b === 1'b1);
    phase  = (phase + 1) % 4;
    tick   = (phase == 0);
    if (tick) tick_count++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx_a = v;
    else            rx_b = v;
  endtask

  // One bit period is 16 ticks = 64 clocks. A low stop bit is held for 12 ticks
  // (past the mid-stop sample) and the line then returns high.
  task automatic send_frame(input int which, input logic [7:0] d, input int nbits,
                            input logic stop_lvl, input int nstop, output int start_tk);
    start_tk = tick_count;
    set_line(which, 1'b0);
    wait_clks(64);
    for (int i = 0; i < nbits; i++) begin
      set_line(which, d[i]);
      wait_clks(64);
    end
    if (stop_lvl) begin
      set_line(which, 1'b1);
      wait_clks(64 * nstop);
    end else begin
      set_line(which, 1'b0);
      wait_clks(48);
      set_line(which, 1'b1);
      wait_clks(16 + 64 * (nstop - 1));
    end
  endtask

  task automatic pop_a(output logic [7:0] d, output logic e, output int t);
    if (da_q.size() > 0) begin
      d = da_q.pop_front(); e = ea_q.pop_front(); t = ta_q.pop_front();
    end else begin
      d = 'x; e = 1'bx; t = -1;
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [6:0] d7;
    logic       e;
    int         t, t2, st;

    // Reset state
    wait_clks(4);
    check("reset_data_a", data_a, 8'h00);
    check("reset_done_a", done_a, 1'b0);
    check("reset_err_a",  err_a,  1'b0);
    check("reset_data_b", data_b, 7'h00);
    check("reset_done_b", done_b, 1'b0);
    rst = 1'b0;
    wait_clks(40);

    // Single 0x55 frame
    send_frame(0, 8'h55, 8, 1'b1, 1, st);
    wait_clks(64);
    check("p1_count", da_q.size(), 1);
    pop_a(d, e, t);
    check("p1_data", d, 8'h55);
    check("p1_err",  e, 1'b0);
    check("p1_latency_ok", (t - st >= 152 && t - st <= 153), 1'b1);

    // Back-to-back 0xA3, 0x0F with no idle gap
    send_frame(0, 8'hA3, 8, 1'b1, 1, st);
    send_frame(0, 8'h0F, 8, 1'b1, 1, st);
    wait_clks(64);
    check("b2b_count", da_q.size(), 2);
    pop_a(d, e, t);
    check("b2b_data0", d, 8'hA3);
    check("b2b_err0",  e, 1'b0);
    pop_a(d, e, t2);
    check("b2b_data1", d, 8'h0F);
    check("b2b_err1",  e, 1'b0);
    check("b2b_spacing", t2 - t, 160);

    // 4-tick low glitch on an idle line, then a good 0x3C
    rx_a = 1'b0;
    wait_clks(16);
    rx_a = 1'b1;
    wait_clks(200);
    check("glitch_count", da_q.size(), 0);
    check("glitch_hold",  data_a, 8'h0F);
    send_frame(0, 8'h3C, 8, 1'b1, 1, st);
    wait_clks(64);
    check("post_glitch_count", da_q.size(), 1);
    pop_a(d, e, t);
    check("post_glitch_data", d, 8'h3C);
    check("post_glitch_err",  e, 1'b0);

    // 0xC6 with low stop bit, then 0x12 clears the error
    send_frame(0, 8'hC6, 8, 1'b0, 1, st);
    wait_clks(128);
    check("ferr_count", da_q.size(), 1);
    pop_a(d, e, t);
    check("ferr_data", d, 8'hC6);
    check("ferr_err",  e, 1'b1);
    check("ferr_hold", err_a, 1'b1);
    send_frame(0, 8'h12, 8, 1'b1, 1, st);
    wait_clks(64);
    check("clear_count", da_q.size(), 1);
    pop_a(d, e, t);
    check("clear_data", d, 8'h12);
    check("clear_err",  e, 1'b0);
    check("clear_live", err_a, 1'b0);

    // Reset during data bit 4 of 0x99, then 0x81
    d = 8'h99;
    rx_a = 1'b0;
    wait_clks(64);
    for (int i = 0; i < 4; i++) begin
      rx_a = d[i];
      wait_clks(64);
    end
    rx_a = d[4];
    wait_clks(32);
    rst = 1'b1;
    wait_clks(2);
    rst  = 1'b0;
    rx_a = 1'b1;
    wait_clks(700);
    check("abort_count", da_q.size(), 0);
    check("abort_data",  data_a, 8'h00);
    check("abort_err",   err_a,  1'b0);
    send_frame(0, 8'h81, 8, 1'b1, 1, st);
    wait_clks(64);
    check("after_rst_count", da_q.size(), 1);
    pop_a(d, e, t);
    check("after_rst_data", d, 8'h81);
    check("after_rst_err",  e, 1'b0);

    // 7 data bits with two stop bits
    send_frame(1, 8'h5A, 7, 1'b1, 2, st);
    wait_clks(64);
    check("b_count", db_q.size(), 1);
    if (db_q.size() > 0) begin
      d7 = db_q.pop_front(); e = eb_q.pop_front(); t = tb_q.pop_front();
    end else begin
      d7 = 'x; e = 1'bx; t = -1;
    end
    check("b_data", d7, 7'h5A);
    check("b_err",  e,  1'b0);
    check("b_latency_ok", (t - st >= 152 && t - st <= 153), 1'b1);
    check("a_quiet_during_b", da_q.size(), 0);

    check("a_pulse_width", dbl_a, 0);
    check("b_pulse_width", dbl_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
